id_imm_ctrl: RTL and testbench
==============================

Name: id_imm_ctrl

Overview:
- Decode-stage immediate controller for the RV64 core.
- Accepts fetched instructions over a valid/ready handshake and classifies the immediate format (I/S/B/U/J/none/illegal).
- Assembles the raw immediate field, then drives the 12-bit/20-bit sign-extension datapath with the correct select and operand. It is also legal to fold that datapath inline.
- Presents a registered, sign-extended 64-bit immediate to the execute stage through a 2-entry skid buffer, with flush and an issue counter.

Parameters:
XLEN, 64, datapath/immediate width
ILEN, 32, instruction width
CNTW, 32, issue-counter width

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high (`RstEnable = 1'b1); sampled on rising clk
flush_i  input  1  kill all buffered entries
inst_valid_i  input  1  upstream instruction valid
inst_ready_o  output  1  block can accept an instruction
inst_i  input  ILEN  instruction word
pc_i  input  XLEN  instruction PC
out_valid_o  output  1  result valid to execute stage
out_ready_i  input  1  execute stage accepts result
imm_o  output  XLEN  sign-extended immediate
immtype_o  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 7 ILLEGAL
pc_o  output  XLEN  PC of presented entry
illegal_o  output  1  opcode not recognised
issue_cnt_o  output  CNTW  count of completed output handshakes

Behaviour:
- Reset (rst=1 at clk edge): state EMPTY; out_valid_o=0; inst_ready_o=1; imm_o, pc_o, issue_cnt_o = 0; immtype_o=0; illegal_o=0. Reset overrides flush and all handshakes.
- Accept = inst_valid_i & inst_ready_o. Output handshake = out_valid_o & out_ready_i.
- inst_ready_o = (state != FULL). It is a registered-state decode only and has no combinational path from out_ready_i.
- Classification uses opcode inst_i[6:0]:
  - I-type: 0000011, 0010011, 0011011, 1100111, 1110011.
  - S-type: 0100011. B-type: 1100011. U-type: 0110111, 0010111. J-type: 1101111.
  - NONE: 0110011, 0111011, 0001111 (fence); imm=0.
  - Anything else: ILLEGAL; imm=0, illegal_o=1 while the entry is presented.
- Immediate assembly:
  - I: inst[31:20], 12-bit select.
  - S: {inst[31:25], inst[11:7]}, 12-bit select.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, treated as a 13-bit value sign-extended from bit 12.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, sign-extended from bit 20.
  - U: {inst[31:12], 12'b0}, sign-extended from bit 31.
  - Shift-immediates are not special-cased; execute masks the shamt.
- Latency: 1 cycle. An instruction accepted at edge N is on the outputs after edge N, unless the skid entry is ahead of it.
- States:
  - EMPTY: accept -> BUSY (out loaded).
  - BUSY:
    - accept & out_ready_i -> BUSY (out replaced, no bubble).
    - accept & ~out_ready_i -> FULL (skid loaded; out held stable).
    - ~accept & out_ready_i -> EMPTY.
    - else hold.
  - FULL: no accept. out_ready_i -> BUSY with out <= skid. Else hold.
- While out_valid_o=1 and out_ready_i=0, imm_o, immtype_o, pc_o and illegal_o must not change.
- Ordering is strict FIFO; the skid entry is never bypassed.
- flush_i=1: next state EMPTY, skid cleared, out_valid_o=0.
  - A same-cycle accept is dropped.
  - A same-cycle output handshake still counts.
  - Data outputs may hold stale values when out_valid_o=0.
- issue_cnt_o increments by 1 per output handshake and wraps from 2^CNTW-1 to 0.

Test Plan:
- Reset then inst_i=0xFFF00093 (addi x1,x0,-1), pc 0x80000000, out_ready_i=1 -> next cycle out_valid_o=1, imm_o=0xFFFFFFFFFFFFFFFF, immtype_o=1, pc_o=0x80000000, issue_cnt_o=1 after the handshake.
- Back-to-back stream, out_ready_i=1:
  - 0xFE112E23 (sw) -> imm 0xFFFFFFFFFFFFFFFC, type 2.
  - 0x00000863 (beq +16) -> imm 0x10, type 3.
  - 0x800002B7 (lui) -> imm 0xFFFFFFFF80000000, type 4.
  - 0xFF9FF06F (jal -8) -> imm 0xFFFFFFFFFFFFFFF8, type 5.
  - Throughput is one result per cycle with no bubbles.
- Backpressure:
  - Hold out_ready_i=0 and offer 3 instructions -> two accepted, inst_ready_o=0 on the third, outputs stable.
  - Raise out_ready_i -> the results appear in order and the third instruction is accepted when state leaves FULL.
- inst_i=0x00000000 -> immtype_o=7, illegal_o=1, imm_o=0. inst_i=0x002081B3 (add) -> immtype_o=0, imm_o=0.
- In FULL, assert flush_i together with inst_valid_i -> next cycle out_valid_o=0, inst_ready_o=1, nothing from the flushed or offered entries is emitted later.
- Preload issue_cnt to 0xFFFFFFFF via a forced sequence (or CNTW=4 with 16 handshakes) -> wraps to 0. Assert rst mid-stream in FULL -> all outputs return to reset values in one cycle.

Source files
------------

// File: rtl/id_imm_ctrl.sv
// Decode-stage immediate controller: classifies the immediate format, sign-extends it,
// and presents it to execute through a 2-entry skid buffer with flush and an issue counter.
module id_imm_ctrl #(
    parameter int XLEN = 64,
    parameter int ILEN = 32,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            inst_valid_i,
    output logic            inst_ready_o,
    input  logic [ILEN-1:0] inst_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      immtype_o,
    output logic [XLEN-1:0] pc_o,
    output logic            illegal_o,
    output logic [CNTW-1:0] issue_cnt_o
);

    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_ILL  = 3'd7
    } imm_type_t;

    state_t          state, state_nxt;
    imm_type_t       dec_type;
    logic [XLEN-1:0] dec_imm;

    logic [XLEN-1:0] out_imm, out_pc, skid_imm, skid_pc;
    imm_type_t       out_type, skid_type;
    logic            out_ill, skid_ill;
    logic [CNTW-1:0] cnt;

    logic accept, out_hs;
    logic load_out_in, load_out_skid, load_skid;

    // NOTE: every variable written in a combinational block gets a default first so no latch is inferred.
    always_comb begin
        dec_type = IMM_ILL;
        dec_imm  = '0;
        case (inst_i[6:0])
            7'b0000011, 7'b0010011, 7'b0011011,
            7'b1100111, 7'b1110011:             dec_type = IMM_I;
            7'b0100011:                         dec_type = IMM_S;
            7'b1100011:                         dec_type = IMM_B;
            7'b0110111, 7'b0010111:             dec_type = IMM_U;
            7'b1101111:                         dec_type = IMM_J;
            7'b0110011, 7'b0111011, 7'b0001111: dec_type = IMM_NONE;
            default:                            dec_type = IMM_ILL;
        endcase
        case (dec_type)
            IMM_I: dec_imm = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
            IMM_S: dec_imm = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            IMM_B: dec_imm = {{(XLEN-13){inst_i[31]}}, inst_i[31], inst_i[7],
                              inst_i[30:25], inst_i[11:8], 1'b0};
            IMM_U: dec_imm = {{(XLEN-32){inst_i[31]}}, inst_i[31:12], 12'b0};
            IMM_J: dec_imm = {{(XLEN-21){inst_i[31]}}, inst_i[31], inst_i[19:12],
                              inst_i[20], inst_i[30:21], 1'b0};
            default: dec_imm = '0;
        endcase
    end

    assign accept = inst_valid_i & inst_ready_o;
    assign out_hs = out_valid_o & out_ready_i;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) state_nxt = BUSY;
                BUSY: begin
                    if (accept && !out_ready_i)      state_nxt = FULL;
                    else if (!accept && out_ready_i) state_nxt = EMPTY;
                end
                FULL:  if (out_ready_i) state_nxt = BUSY;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_comb begin
        inst_ready_o = (state != FULL);
        out_valid_o  = (state != EMPTY);
    end

    // The skid entry always drains to the output before any newer instruction.
    always_comb begin
        load_out_in   = accept & ~flush_i & ((state == EMPTY) | ((state == BUSY) & out_ready_i));
        load_out_skid = (state == FULL) & out_ready_i & ~flush_i;
        load_skid     = (state == BUSY) & accept & ~out_ready_i & ~flush_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_imm  <= '0;
            out_type <= IMM_NONE;
            out_pc   <= '0;
            out_ill  <= 1'b0;
        end else if (load_out_in) begin
            out_imm  <= dec_imm;
            out_type <= dec_type;
            out_pc   <= pc_i;
            out_ill  <= (dec_type == IMM_ILL);
        end else if (load_out_skid) begin
            out_imm  <= skid_imm;
            out_type <= skid_type;
            out_pc   <= skid_pc;
            out_ill  <= skid_ill;
        end
    end

    // NOTE: skid data needs no reset; its contents are only observed when the state is FULL.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_imm  <= dec_imm;
            skid_type <= dec_type;
            skid_pc   <= pc_i;
            skid_ill  <= (dec_type == IMM_ILL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)         cnt <= '0;
        else if (out_hs) cnt <= cnt + CNTW'(1);
    end

    assign imm_o       = out_imm;
    assign immtype_o   = out_type;
    assign pc_o        = out_pc;
    assign illegal_o   = out_ill;
    assign issue_cnt_o = cnt;

endmodule

// File: tb/tb_id_imm_ctrl.sv
// Self-checking bench for id_imm_ctrl: table-driven vectors feeding a scoreboard queue,
// plus directed backpressure, flush, counter-wrap and mid-stream reset sequences.
module tb_id_imm_ctrl;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam int CNTW = 4;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  typ;
    } vec_t;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  typ;
        logic [63:0] pc;
        logic        ill;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst, flush_i, inst_valid_i, inst_ready_o, out_valid_o, out_ready_i, illegal_o;
    logic [ILEN-1:0] inst_i;
    logic [XLEN-1:0] pc_i, imm_o, pc_o;
    logic [2:0]      immtype_o;
    logic [CNTW-1:0] issue_cnt_o;

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    logic [CNTW-1:0] exp_cnt;
    logic [63:0] cur_imm;
    logic [2:0]  cur_type;
    vec_t        vecs[10];

    id_imm_ctrl #(.XLEN(XLEN), .ILEN(ILEN), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
        .inst_i(inst_i), .pc_i(pc_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .imm_o(imm_o), .immtype_o(immtype_o), .pc_o(pc_o),
        .illegal_o(illegal_o), .issue_cnt_o(issue_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare the presented entry to the queue head, pop on handshake, push on accept.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            exp_cnt = '0;
        end else begin
            check("issue_cnt", 64'(issue_cnt_o), 64'(exp_cnt));
            if (out_valid_o) begin
                if (q.size() == 0) begin
                    check("spurious_valid", 64'(out_valid_o), 64'd0);
                end else begin
                    check("imm", imm_o, q[0].imm);
                    check("immtype", 64'(immtype_o), 64'(q[0].typ));
                    check("pc", pc_o, q[0].pc);
                    check("illegal", 64'(illegal_o), 64'(q[0].ill));
                    if (out_ready_i) void'(q.pop_front());
                end
                if (out_ready_i) exp_cnt = exp_cnt + 1'b1;
            end
            if (flush_i) q.delete();
            else if (inst_valid_i && inst_ready_o)
                q.push_back('{imm: cur_imm, typ: cur_type, pc: pc_i, ill: (cur_type == 3'd7)});
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input vec_t v, input logic [63:0] pc);
        inst_i       = v.inst;
        pc_i         = pc;
        cur_imm      = v.imm;
        cur_type     = v.typ;
        inst_valid_i = 1'b1;
    endtask

    // Offer one instruction and hold it until accepted (bounded).
    task automatic drive(input vec_t v, input logic [63:0] pc);
        int n;
        offer(v, pc);
        n = 0;
        while (!inst_ready_o && n < 50) begin
            next_cycle();
            n++;
        end
        check("accept_ready", 64'(inst_ready_o), 64'd1);
        next_cycle();
        inst_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready_i = 1'b1;
        n = 0;
        while (out_valid_o && n < 50) begin
            next_cycle();
            n++;
        end
        check("drain", 64'(out_valid_o), 64'd0);
    endtask

    task automatic fill_full();
        out_ready_i = 1'b0;
        drive(vecs[1], 64'h1000);
        drive(vecs[2], 64'h1004);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1};
        vecs[1] = '{32'hFE112E23, 64'hFFFFFFFFFFFFFFFC, 3'd2};
        vecs[2] = '{32'h00000863, 64'h0000000000000010, 3'd3};
        vecs[3] = '{32'h800002B7, 64'hFFFFFFFF80000000, 3'd4};
        vecs[4] = '{32'hFF9FF06F, 64'hFFFFFFFFFFFFFFF8, 3'd5};
        vecs[5] = '{32'h00000000, 64'h0000000000000000, 3'd7};
        vecs[6] = '{32'h002081B3, 64'h0000000000000000, 3'd0};
        vecs[7] = '{32'h0000000F, 64'h0000000000000000, 3'd0};
        vecs[8] = '{32'h00001097, 64'h0000000000001000, 3'd4};
        vecs[9] = '{32'h00812083, 64'h0000000000000008, 3'd1};

        rst = 1'b1; flush_i = 1'b0; inst_valid_i = 1'b0; out_ready_i = 1'b0;
        inst_i = '0; pc_i = '0; cur_imm = '0; cur_type = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_ready", 64'(inst_ready_o), 64'd1);
        check("rst_imm", imm_o, 64'd0);
        check("rst_pc", pc_o, 64'd0);
        check("rst_type", 64'(immtype_o), 64'd0);
        check("rst_illegal", 64'(illegal_o), 64'd0);
        check("rst_cnt", 64'(issue_cnt_o), 64'd0);

        // First transaction: one-cycle latency, counter 1 after the handshake.
        out_ready_i = 1'b1;
        drive(vecs[0], 64'h80000000);
        check("t1_valid", 64'(out_valid_o), 64'd1);
        check("t1_imm", imm_o, 64'hFFFFFFFFFFFFFFFF);
        check("t1_type", 64'(immtype_o), 64'd1);
        check("t1_pc", pc_o, 64'h80000000);
        next_cycle();
        check("t1_cnt", 64'(issue_cnt_o), 64'd1);

        // Back-to-back stream twice through the table; counter wraps past 15.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 10; i++) begin
                drive(vecs[i], 64'h2000 + 64'(pass * 64 + i * 4));
                check("no_bubble", 64'(out_valid_o), 64'd1);
            end
        end
        drain();

        // Backpressure: two accepted, third stalls while FULL, then released in order.
        fill_full();
        offer(vecs[3], 64'h1008);
        check("bp_ready_full", 64'(inst_ready_o), 64'd0);
        next_cycle();
        next_cycle();
        check("bp_still_full", 64'(inst_ready_o), 64'd0);
        check("bp_held_imm", imm_o, vecs[1].imm);
        out_ready_i = 1'b1;
        drive(vecs[3], 64'h1008);
        drain();

        // Flush in FULL with a same-cycle offer: everything disappears.
        fill_full();
        offer(vecs[4], 64'h3000);
        flush_i = 1'b1;
        next_cycle();
        flush_i = 1'b0;
        inst_valid_i = 1'b0;
        check("flush_valid", 64'(out_valid_o), 64'd0);
        check("flush_ready", 64'(inst_ready_o), 64'd1);
        out_ready_i = 1'b1;
        repeat (4) next_cycle();

        // Flush in BUSY with accept and a handshake in the same cycle.
        out_ready_i = 1'b0;
        drive(vecs[8], 64'h4000);
        offer(vecs[9], 64'h4004);
        out_ready_i = 1'b1;
        flush_i = 1'b1;
        next_cycle();
        flush_i = 1'b0;
        inst_valid_i = 1'b0;
        check("flush_busy_valid", 64'(out_valid_o), 64'd0);
        repeat (3) next_cycle();

        // Reset mid-stream in FULL.
        fill_full();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        check("mrst_valid", 64'(out_valid_o), 64'd0);
        check("mrst_ready", 64'(inst_ready_o), 64'd1);
        check("mrst_imm", imm_o, 64'd0);
        check("mrst_pc", pc_o, 64'd0);
        check("mrst_type", 64'(immtype_o), 64'd0);
        check("mrst_cnt", 64'(issue_cnt_o), 64'd0);

        // Post-reset sanity: illegal entry flows through cleanly.
        out_ready_i = 1'b1;
        drive(vecs[5], 64'h5000);
        check("post_illegal", 64'(illegal_o), 64'd1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
